// File: rtl/example_mul_share_arb.sv
// Round-robin arbiter sharing one signed A_W x B_W multiplier among NUM_REQ requesters.
// Results leave a MUL_LAT-deep pipeline tagged with the owning requester index.
module example_mul_share_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned A_W     = 14,
    parameter int unsigned B_W     = 7,
    parameter int unsigned MUL_LAT = 3,
    localparam int unsigned P_W    = A_W + B_W,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_vld,
    output logic [NUM_REQ-1:0]     req_rdy,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_vld,
    input  logic                   res_rdy,
    output logic [ID_W-1:0]        res_id,
    output logic [P_W-1:0]         res_p,
    output logic                   busy
);

    logic                   stall;
    logic                   found;
    logic                   grant;
    int unsigned            win_idx;
    int unsigned            idx;
    logic [ID_W-1:0]        win_id;
    logic [ID_W-1:0]        ptr_q, ptr_d;

    logic                   s1_vld_q, s1_vld_d;
    logic [ID_W-1:0]        s1_id_q, s1_id_d;
    logic [A_W-1:0]         s1_a_q, s1_a_d;
    logic [B_W-1:0]         s1_b_q, s1_b_d;
    logic signed [P_W-1:0]  a_ext, b_ext, s1_p;

    assign stall = res_vld & ~res_rdy;

    // Search starts at ptr and wraps; first valid requester wins.
    always_comb begin
        found   = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr_q) + off) % NUM_REQ;
            if (!found && req_vld[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
        win_id  = ID_W'(win_idx);
        grant   = found & ~stall;
        req_rdy = '0;
        if (grant) begin
            req_rdy[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_id_d  = s1_id_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        if (!stall) begin
            s1_vld_d = grant;
            if (grant) begin
                s1_id_d = win_id;
                s1_a_d  = req_a[win_idx*A_W +: A_W];
                s1_b_d  = req_b[win_idx*B_W +: B_W];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_id_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
        end
    end

    // Registered operands feed the multiplier so the DSP input registers absorb stage 1.
    assign a_ext = {{B_W{s1_a_q[A_W-1]}}, s1_a_q};
    assign b_ext = {{A_W{s1_b_q[B_W-1]}}, s1_b_q};
    assign s1_p  = a_ext * b_ext;

    if (MUL_LAT == 1) begin : g_lat1
        assign res_vld = s1_vld_q;
        assign res_id  = s1_id_q;
        assign res_p   = s1_p;
        assign busy    = s1_vld_q;
    end else begin : g_pipe
        localparam int unsigned NS = MUL_LAT - 1;

        logic [NS-1:0]   vld_q, vld_d;
        logic [ID_W-1:0] id_q [NS];
        logic [ID_W-1:0] id_d [NS];
        logic [P_W-1:0]  p_q  [NS];
        logic [P_W-1:0]  p_d  [NS];

        always_comb begin
            vld_d = vld_q;
            id_d  = id_q;
            p_d   = p_q;
            if (!stall) begin
                vld_d[0] = s1_vld_q;
                id_d[0]  = s1_id_q;
                p_d[0]   = s1_p;
                for (int i = 1; i < NS; i++) begin
                    vld_d[i] = vld_q[i-1];
                    id_d[i]  = id_q[i-1];
                    p_d[i]   = p_q[i-1];
                end
            end
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < NS; i++) begin
                    id_q[i] <= '0;
                    p_q[i]  <= '0;
                end
            end else begin
                vld_q <= vld_d;
                for (int i = 0; i < NS; i++) begin
                    id_q[i] <= id_d[i];
                    p_q[i]  <= p_d[i];
                end
            end
        end

        assign res_vld = vld_q[NS-1];
        assign res_id  = id_q[NS-1];
        assign res_p   = p_q[NS-1];
        assign busy    = s1_vld_q | (|vld_q);
    end

endmodule

// File: tb/tb_example_mul_share_arb.sv
// Self-checking bench for example_mul_share_arb: vector table, cycle model with
// result scoreboard, and hand-written arbitration / stall / reset sequences.
module tb_example_mul_share_arb;

    localparam int N   = 4;
    localparam int AW  = 14;
    localparam int BW  = 7;
    localparam int LAT = 3;
    localparam int PW  = AW + BW;
    localparam int IW  = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rdy;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            res_vld;
    logic            res_rdy;
    logic [IW-1:0]   res_id;
    logic [PW-1:0]   res_p;
    logic            busy;

    example_mul_share_arb #(
        .NUM_REQ(N),
        .A_W    (AW),
        .B_W    (BW),
        .MUL_LAT(LAT)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_a   (req_a),
        .req_b   (req_b),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res_id  (res_id),
        .res_p   (res_p),
        .busy    (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int id;
        int p;
    } res_t;

    typedef struct {
        int id;
        int a;
        int b;
        int p;
    } vec_t;

    int           n_chk = 0;
    int           n_err = 0;
    res_t         sb_q[$];
    int           dut_log[$];
    int           popped = 0;
    int           ptr_m = 0;
    logic [LAT-1:0] vpipe_m = '0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic int prod_of(input int id);
        logic signed [AW-1:0] a;
        logic signed [BW-1:0] b;
        a = req_a[id*AW +: AW];
        b = req_b[id*BW +: BW];
        return int'(a) * int'(b);
    endfunction

    // Cycle model: predicts req_rdy/res_vld/busy and queues expected results at grant time.
    initial begin
        logic         exp_vld;
        logic         stall_m;
        int           win;
        logic [N-1:0] exp_rdy;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                vpipe_m = '0;
                sb_q.delete();
                ptr_m = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (req_vld[i] && req_rdy[i]) dut_log.push_back(i);
                end
                exp_vld = vpipe_m[LAT-1];
                stall_m = exp_vld && !res_rdy;
                win = -1;
                if (!stall_m) begin
                    for (int off = 0; off < N; off++) begin
                        if (win < 0 && req_vld[(ptr_m + off) % N]) win = (ptr_m + off) % N;
                    end
                end
                exp_rdy = '0;
                if (win >= 0) exp_rdy[win] = 1'b1;
                check("mon_req_rdy", req_rdy, exp_rdy);
                check("mon_res_vld", res_vld, exp_vld);
                check("mon_busy", busy, |vpipe_m);
                if (exp_vld) begin
                    if (sb_q.size() == 0) begin
                        fail("mon_sb_empty");
                    end else begin
                        check("mon_res_id", res_id, sb_q[0].id);
                        check("mon_res_p", $signed(res_p), sb_q[0].p);
                        if (res_rdy) begin
                            sb_q.delete(0);
                            popped++;
                        end
                    end
                end
                if (!stall_m) begin
                    for (int s = LAT - 1; s > 0; s--) vpipe_m[s] = vpipe_m[s-1];
                    vpipe_m[0] = (win >= 0);
                    if (win >= 0) begin
                        sb_q.push_back('{id: win, p: prod_of(win)});
                        ptr_m = (win + 1) % N;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input int id, input int a, input int b);
        req_a[id*AW +: AW] = AW'(a);
        req_b[id*BW +: BW] = BW'(b);
    endtask

    task automatic send(input int id, input int a, input int b);
        int n0;
        bit ok;
        set_req(id, a, b);
        req_vld[id] = 1'b1;
        n0 = dut_log.size();
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (dut_log.size() > n0) begin
                ok = 1'b1;
                break;
            end
        end
        req_vld[id] = 1'b0;
        if (!ok) fail("send_grant");
    endtask

    task automatic wait_log(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (dut_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail(name);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (vpipe_m == '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail(name);
        else check(name, busy, 0);
    endtask

    task automatic reset_dut();
        ap_rst_n = 1'b0;
        repeat (2) tick();
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   lat;
        int   n0;
        int   p0;
        logic [IW-1:0] cap_id;
        logic [PW-1:0] cap_p;

        vecs[0] = '{id: 0, a: -8192, b: -64, p: 524288};
        vecs[1] = '{id: 2, a: 8191,  b: -64, p: -524224};
        vecs[2] = '{id: 2, a: 0,     b: -64, p: 0};
        vecs[3] = '{id: 1, a: -1,    b: -1,  p: 1};
        vecs[4] = '{id: 3, a: 8191,  b: 63,  p: 516033};
        vecs[5] = '{id: 0, a: -8192, b: 63,  p: -516096};
        vecs[6] = '{id: 2, a: 123,   b: -5,  p: -615};

        ap_rst_n = 1'b1;
        req_vld  = '0;
        req_a    = '0;
        req_b    = '0;
        res_rdy  = 1'b1;
        #1 ap_rst_n = 1'b0;
        tick();
        check("rst_res_vld", res_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_p", $signed(res_p), 0);
        check("rst_req_rdy", req_rdy, 0);
        tick();
        ap_rst_n = 1'b1;

        // T1/T2 and extra products: single requester, latency and value.
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].id, vecs[v].a, vecs[v].b);
            lat = 0;
            while (!res_vld && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("tbl%0d_lat", v), lat, LAT - 1);
            check($sformatf("tbl%0d_id", v), res_id, vecs[v].id);
            check($sformatf("tbl%0d_p", v), $signed(res_p), vecs[v].p);
            tick();
        end
        wait_idle("tbl_idle");

        // T3: all requesters contend; grants rotate from 0.
        reset_dut();
        for (int i = 0; i < N; i++) set_req(i, 1000 * i - 1500, 7 * i - 20);
        n0 = dut_log.size();
        req_vld = '1;
        wait_log(n0 + 6, "t3_grants");
        req_vld = '0;
        for (int k = 0; k < 6; k++) check($sformatf("t3_grant%0d", k), dut_log[n0 + k], k % N);
        wait_idle("t3_idle");

        // T4: stream from req 1 while the consumer stalls for 5 cycles.
        p0 = popped;
        fork
            begin
                for (int k = 0; k < 8; k++) send(1, k * 1000 - 3000, k * 9 - 30);
            end
            begin
                repeat (4) tick();
                res_rdy = 1'b0;
                cap_id = res_id;
                cap_p  = res_p;
                check("t4_vld_at_stall", res_vld, 1);
                repeat (5) begin
                    tick();
                    check("t4_hold_vld", res_vld, 1);
                    check("t4_rdy_zero", req_rdy, 0);
                    check("t4_hold_id", res_id, cap_id);
                    check("t4_hold_p", $signed(res_p), $signed(cap_p));
                end
                res_rdy = 1'b1;
            end
        join
        wait_idle("t4_idle");
        check("t4_count", popped - p0, 8);
        check("t4_sb_empty", sb_q.size(), 0);

        // T5: ptr=2 with reqs 1 and 3 pending; then a withdrawn request.
        reset_dut();
        send(1, 100, -3);
        set_req(1, -77, 5);
        set_req(3, 4321, -2);
        n0 = dut_log.size();
        req_vld[1] = 1'b1;
        req_vld[3] = 1'b1;
        wait_log(n0 + 2, "t5_grants");
        req_vld = '0;
        check("t5_first", dut_log[n0], 3);
        check("t5_second", dut_log[n0 + 1], 1);
        res_rdy = 1'b0;
        lat = 0;
        while (!res_vld && lat < 20) begin
            tick();
            lat++;
        end
        check("t5_stalled", res_vld, 1);
        n0 = dut_log.size();
        req_vld[1] = 1'b1;
        repeat (3) tick();
        req_vld[1] = 1'b0;
        res_rdy = 1'b1;
        wait_idle("t5_idle");
        check("t5_withdrawn", dut_log.size(), n0);

        // T6: reset with two entries in flight, then arbitration restarts at index 0.
        reset_dut();
        set_req(2, -500, 11);
        n0 = dut_log.size();
        req_vld[2] = 1'b1;
        wait_log(n0 + 2, "t6_fill");
        req_vld = '0;
        check("t6_busy_before", busy, 1);
        check("t6_vld_before", res_vld, 0);
        ap_rst_n = 1'b0;
        #1;
        check("t6_rst_vld", res_vld, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_p", $signed(res_p), 0);
        repeat (2) tick();
        ap_rst_n = 1'b1;
        set_req(3, 9, 9);
        n0 = dut_log.size();
        req_vld[2] = 1'b1;
        req_vld[3] = 1'b1;
        wait_log(n0 + 1, "t6_grant");
        req_vld = '0;
        check("t6_first_grant", dut_log[n0], 2);
        wait_idle("t6_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
